// File: rtl/miriscv_lsu_pkg.sv
// miriscv_lsu_pkg: shared encodings for the load-store unit.
//   LDST_*      : decoder mem_size encodings (sign-extending B/H/W, unsigned BU/HU)
//   lsu_state_e : LSU transaction state machine states
package miriscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_WAIT_GNT,
    LSU_WAIT_RVALID
  } lsu_state_e;

endpackage

// File: rtl/miriscv_lsu_fmt.sv
// miriscv_lsu_fmt: combinational data formatting for the LSU.
//   size, off, we, wdata_in -> fault (misaligned/illegal), be, wdata_out (lane-replicated)
//   rsize, roff, rdata      -> ldata (extracted and sign/zero extended load value)
module miriscv_lsu_fmt
  import miriscv_lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic        we,
  input  logic [31:0] wdata_in,
  output logic        fault,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  input  logic [2:0]  rsize,
  input  logic [1:0]  roff,
  input  logic [31:0] rdata,
  output logic [31:0] ldata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    fault = 1'b0;
    case (size)
      LDST_B:  fault = 1'b0;
      LDST_BU: fault = we;
      LDST_H:  fault = off[0];
      LDST_HU: fault = off[0] | we;
      LDST_W:  fault = |off;
      default: fault = 1'b1;
    endcase
  end

  // Byte enables and lanes depend only on access width, not signedness.
  always_comb begin
    be        = 4'b1111;
    wdata_out = wdata_in;
    case (size[1:0])
      2'd0: begin
        be        = 4'b0001 << off;
        wdata_out = {4{wdata_in[7:0]}};
      end
      2'd1: begin
        be        = off[1] ? 4'b1100 : 4'b0011;
        wdata_out = {2{wdata_in[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_out = wdata_in;
      end
    endcase
  end

  always_comb begin
    rbyte = 8'(rdata >> {roff, 3'b000});
    rhalf = 16'(rdata >> {roff[1], 4'b0000});
    case (rsize)
      LDST_B:  ldata = {{24{rbyte[7]}}, rbyte};
      LDST_BU: ldata = {24'd0, rbyte};
      LDST_H:  ldata = {{16{rhalf[15]}}, rhalf};
      LDST_HU: ldata = {16'd0, rhalf};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// miriscv_lsu: load-store unit, request/grant/response data-memory master.
//   clk_i, rst_i (sync, active-high)
//   lsu_req_i/we_i/size_i/addr_i/data_i : decoded access from the core (held while stalled)
//   lsu_data_o, lsu_stall_req_o, lsu_misaligned_o, lsu_timeout_o : results back to the core
//   data_req_o/we_o/be_o/addr_o/wdata_o, data_gnt_i/rvalid_i/rdata_i : memory port
module miriscv_lsu
  import miriscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_CNT_W       = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misaligned_o,
  output logic        lsu_timeout_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  lsu_state_e          state;
  logic [1:0]          off_q;
  logic [2:0]          size_q;
  logic                we_q;
  logic [TO_CNT_W-1:0] to_cnt;

  logic        fault;
  logic        to_hit;
  logic [31:0] ldata;

  miriscv_lsu_fmt u_fmt (
    .size      (lsu_size_i),
    .off       (lsu_addr_i[1:0]),
    .we        (lsu_we_i),
    .wdata_in  (lsu_data_i),
    .fault     (fault),
    .be        (data_be_o),
    .wdata_out (data_wdata_o),
    .rsize     (size_q),
    .roff      (off_q),
    .rdata     (data_rdata_i),
    .ldata     (ldata)
  );

  assign data_addr_o = {lsu_addr_i[31:2], 2'b00};
  assign data_we_o   = lsu_we_i;
  assign to_hit      = (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));

  // Request/stall/fault outputs are combinational so an access issues in the
  // same cycle it is decoded; all are forced low while reset is asserted.
  always_comb begin
    data_req_o       = 1'b0;
    lsu_stall_req_o  = 1'b0;
    lsu_misaligned_o = 1'b0;
    lsu_timeout_o    = 1'b0;
    lsu_data_o       = '0;
    if (!rst_i) begin
      case (state)
        LSU_IDLE: begin
          if (lsu_req_i) begin
            if (fault) begin
              lsu_misaligned_o = 1'b1;
            end else begin
              data_req_o      = 1'b1;
              lsu_stall_req_o = 1'b1;
            end
          end
        end
        LSU_WAIT_GNT: begin
          data_req_o      = 1'b1;
          lsu_stall_req_o = 1'b1;
        end
        LSU_WAIT_RVALID: begin
          if (data_rvalid_i) begin
            if (!we_q) lsu_data_o = ldata;
          end else if (to_hit) begin
            lsu_timeout_o = 1'b1;
          end else begin
            lsu_stall_req_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= LSU_IDLE;
      off_q  <= '0;
      size_q <= '0;
      we_q   <= 1'b0;
      to_cnt <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          to_cnt <= '0;
          if (lsu_req_i && !fault) begin
            off_q  <= lsu_addr_i[1:0];
            size_q <= lsu_size_i;
            we_q   <= lsu_we_i;
            state  <= data_gnt_i ? LSU_WAIT_RVALID : LSU_WAIT_GNT;
          end
        end
        LSU_WAIT_GNT: begin
          if (data_gnt_i) state <= LSU_WAIT_RVALID;
        end
        LSU_WAIT_RVALID: begin
          if (data_rvalid_i || to_hit) begin
            state  <= LSU_IDLE;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// tb_miriscv_lsu: directed self-checking bench for miriscv_lsu (TIMEOUT_CYCLES=4).
module tb_miriscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o, lsu_misaligned_o, lsu_timeout_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_gnt_i, data_rvalid_i;
  logic [31:0] data_rdata_i;

  int unsigned total = 0;
  int unsigned bad   = 0;

  miriscv_lsu #(.TIMEOUT_CYCLES(4), .TO_CNT_W(16)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .lsu_req_i        (lsu_req_i),
    .lsu_we_i         (lsu_we_i),
    .lsu_size_i       (lsu_size_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_data_i       (lsu_data_i),
    .lsu_data_o       (lsu_data_o),
    .lsu_stall_req_o  (lsu_stall_req_o),
    .lsu_misaligned_o (lsu_misaligned_o),
    .lsu_timeout_o    (lsu_timeout_o),
    .data_req_o       (data_req_o),
    .data_we_o        (data_we_o),
    .data_be_o        (data_be_o),
    .data_addr_o      (data_addr_o),
    .data_wdata_o     (data_wdata_o),
    .data_gnt_i       (data_gnt_i),
    .data_rvalid_i    (data_rvalid_i),
    .data_rdata_i     (data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Check the four control outputs at mid-cycle.
  task automatic ctl(input string tag, input logic req, input logic stall,
                     input logic mis, input logic to);
    chk({tag, ".req"},   {31'd0, data_req_o},       {31'd0, req});
    chk({tag, ".stall"}, {31'd0, lsu_stall_req_o},  {31'd0, stall});
    chk({tag, ".mis"},   {31'd0, lsu_misaligned_o}, {31'd0, mis});
    chk({tag, ".to"},    {31'd0, lsu_timeout_o},    {31'd0, to});
  endtask

  task automatic drive(input logic req, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] data);
    lsu_req_i  = req;
    lsu_we_i   = we;
    lsu_size_i = size;
    lsu_addr_i = addr;
    lsu_data_i = data;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b1, 1'b0, 3'd2, 32'h0000_0000, 32'h0);
    data_gnt_i = 1'b1; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    tick(); tick();
    #4;
    ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.data", lsu_data_o, 32'h0);
    tick();
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    data_gnt_i = 1'b0;
    #4;
    ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // LB 0x1003, grant in issue cycle, response next cycle
    tick();
    drive(1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'h0);
    data_gnt_i = 1'b1;
    #4;
    ctl("lb.issue", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lb.be",   {28'd0, data_be_o}, 32'h8);
    chk("lb.addr", data_addr_o, 32'h0000_1000);
    chk("lb.we",   {31'd0, data_we_o}, 32'h0);
    tick();
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h8012_3456;
    #4;
    ctl("lb.resp", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lb.data", lsu_data_o, 32'hFFFF_FF80);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    data_rvalid_i = 1'b0;
    #4;
    chk("lb.after", lsu_data_o, 32'h0);

    // SH 0x2002, grant after 3 wait cycles
    tick();
    drive(1'b1, 1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD);
    for (int i = 0; i < 4; i++) begin
      data_gnt_i = (i == 3);
      #4;
      ctl($sformatf("sh.req%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("sh.be%0d", i),    {28'd0, data_be_o}, 32'hC);
      chk($sformatf("sh.wdata%0d", i), data_wdata_o, 32'hABCD_ABCD);
      chk($sformatf("sh.we%0d", i),    {31'd0, data_we_o}, 32'h1);
      tick();
    end
    data_gnt_i = 1'b0;
    #4;
    ctl("sh.wait", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    data_rvalid_i = 1'b1;
    #4;
    ctl("sh.resp", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    data_rvalid_i = 1'b0;

    // Misaligned LW, then illegal store size BU
    tick();
    drive(1'b1, 1'b0, 3'd2, 32'h0000_3001, 32'h0);
    data_gnt_i = 1'b1;
    #4;
    ctl("lw.mis", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 3'd4, 32'h0000_3000, 32'h0);
    #4;
    ctl("sbu.mis", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #4;
    ctl("mis.after", 1'b0, 1'b0, 1'b0, 1'b0);

    // SB 0x0102 lane replication
    tick();
    drive(1'b1, 1'b1, 3'd0, 32'h0000_0102, 32'h0000_00AB);
    #4;
    chk("sb.be",    {28'd0, data_be_o}, 32'h4);
    chk("sb.wdata", data_wdata_o, 32'hABAB_ABAB);
    tick();
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
    #4;
    ctl("sb.resp", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    data_rvalid_i = 1'b0;

    // LH 0x0000 sign extension of low half
    tick();
    drive(1'b1, 1'b0, 3'd1, 32'h0000_0000, 32'h0);
    data_gnt_i = 1'b1;
    #4;
    chk("lh.be", {28'd0, data_be_o}, 32'h3);
    tick();
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_8001;
    #4;
    chk("lh.data", lsu_data_o, 32'hFFFF_8001);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    data_rvalid_i = 1'b0;

    // LHU 0x0002 with no response -> timeout on 4th WAIT_RVALID cycle
    tick();
    drive(1'b1, 1'b0, 3'd5, 32'h0000_0002, 32'h0);
    data_gnt_i = 1'b1;
    #4;
    chk("lhu.be", {28'd0, data_be_o}, 32'hC);
    tick();
    data_gnt_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #4;
      ctl($sformatf("lhu.wait%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    #4;
    ctl("lhu.to", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    data_rvalid_i = 1'b1; data_rdata_i = 32'hFEDC_0000;
    #4;
    ctl("lhu.late", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lhu.late.data", lsu_data_o, 32'h0);
    tick();
    data_rvalid_i = 1'b0;

    // Reset in WAIT_GNT, then LBU 0x4001
    tick();
    drive(1'b1, 1'b0, 3'd4, 32'h0000_4001, 32'h0);
    data_gnt_i = 1'b0;
    #4;
    ctl("lbu.issue", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    #4;
    ctl("lbu.wgnt", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    rst_i = 1'b1;
    #4;
    ctl("lbu.inrst", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 3'd4, 32'h0000_4001, 32'h0);
    data_rvalid_i = 1'b1; data_rdata_i = 32'h0000_9900;
    #4;
    ctl("lbu.postrst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lbu.postrst.data", lsu_data_o, 32'h0);
    tick();
    drive(1'b1, 1'b0, 3'd4, 32'h0000_4001, 32'h0);
    data_gnt_i = 1'b1; data_rvalid_i = 1'b0;
    #4;
    ctl("lbu2.issue", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lbu2.be", {28'd0, data_be_o}, 32'h2);
    tick();
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
    #4;
    ctl("lbu2.resp", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lbu2.data", lsu_data_o, 32'h0000_0099);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    data_rvalid_i = 1'b0;
    #4;
    ctl("end.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
